pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Instruction-fetch stage that consumes the next-PC selection. Owns the architectural PC register and issues single-outstanding requests to instruction memory over a Req/Ack handshake. Delivers {PC, instruction, valid} into the IF/ID register. Handles hazard stalls through a one-entry skid buffer, and handles jump/branch redirects, including redirects that arrive while a memory request is still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction value driven on IF_Instr when the slot is invalid.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard unit: hold the IF/ID outputs.
- Redirect_Valid  in  1  taken jump or branch this cycle.
- Redirect_PC  in  32  target from the PC mux (PC_Result).
- IMem_Req  out  1  fetch request.
- IMem_Addr  out  32  fetch address; word aligned.
- IMem_Ack  in  1  data valid; may assert in the same cycle as Req.
- IMem_Rdata  in  32  instruction word, valid when Ack=1.
- IF_PC  out  32  PC of the delivered instruction.
- IF_NPC  out  32  IF_PC+4, fed back to the PC mux NPC input.
- IF_Instr  out  32  delivered instruction.
- IF_Valid  out  1  IF/ID slot holds a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; state=IDLE; kill=0; buffer empty.
  - IMem_Req=0; IF_Valid=0; IF_PC=0; IF_Instr=NOP_INSTR.
- Reset mid-request: any outstanding request is abandoned. A late Ack arriving in IDLE is ignored.
- Handshake:
  - IMem_Addr=PC whenever Req=1.
  - Req and Addr must stay stable until the Ack cycle; Req is never retracted.
  - Only one request outstanding. Ack is ignored when Req=0.
- IF_NPC is combinational IF_PC+4, modulo 2^32 (wraps at 32'hFFFF_FFFC).
- States: IDLE, REQ (Req=1), HOLD (Req=0, buffer full).
- IDLE: goes to REQ on the next cycle. Redirect in IDLE loads PC=Redirect_PC.
- REQ, Ack=1, kill=0, Redirect_Valid=0:
  - Stall=0: IF <= {PC, Rdata, valid=1}; PC <= PC+4; stay REQ. A zero-wait memory gives one instruction per cycle.
  - Stall=1: buffer <= {PC, Rdata}; PC <= PC+4; go to HOLD. IF regs hold.
- REQ, Ack=1, kill=1: discard Rdata; PC <= pending target; kill <= 0; stay REQ.
- REQ, Ack=1, Redirect_Valid=1: discard Rdata; PC <= Redirect_PC; stay REQ.
- REQ, Ack=0, Redirect_Valid=1: PC is not changed. Set kill=1 and pending <= Redirect_PC. A later redirect overwrites pending (last one wins).
- REQ, Ack=0, no redirect, Stall=0: IF_Valid <= 0 (bubble).
- HOLD:
  - Redirect_Valid=1: drop buffer; PC <= Redirect_PC; go to REQ.
  - Else Stall=0: IF <= buffer with valid=1; go to REQ.
  - Else stay in HOLD.
- Flush:
  - Any Redirect_Valid cycle writes IF_Valid <= 0 and IF_Instr <= NOP_INSTR.
  - Redirect overrides Stall for the IF slot.
- Stall=1 with no redirect: IF_PC, IF_Instr and IF_Valid all hold.
- Misaligned Redirect_PC: bits [1:0] are forced to 0 on load.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs Fetch_Count[31:0] and Bubble_Count[31:0], both reset to 0.
  - Fetch_Count increments on each cycle that writes IF_Valid=1.
  - Bubble_Count increments on each cycle with Stall=0 that writes IF_Valid=0.
  - Both wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - fetch state encoding (IDLE/REQ/HOLD);
  - RESET_PC default;
  - NOP_INSTR constant;
  - PC increment constant 4.
- No sub-module. The skid buffer and kill logic are small enough to stay inline.

Test Plan:
- Reset release, zero-wait memory (Ack=Req): IMem_Addr is 0,4,8,… on consecutive cycles; IF_Valid=1 from the 2nd post-reset cycle; IF_NPC = IF_PC+4.
- Memory with 3-cycle Ack latency at PC=0x10: Addr holds 0x10 for 3 cycles with Req=1; IF_Valid=0 for 2 bubbles, then IF_Instr=Rdata with IF_PC=0x10.
- Stall=1 for 4 cycles while Ack returns 0x14: IF holds its previous values, state goes to HOLD with Req=0; on Stall=0, IF_PC=0x14 and fetch resumes at 0x18.
- Redirect to 0x100 while a 0x20 request is pending (Ack after 2 cycles): Addr stays 0x20 until Ack; that Rdata never reaches IF; next Addr=0x100; IF_Valid=0 during the redirect cycle.
- Redirect_Valid and Stall asserted together in HOLD: buffer dropped, IF_Valid=0, next Addr = Redirect_PC; redirect to 0x102 fetches 0x100.
- rst_n low mid-request, then Ack pulses during reset: all outputs return to reset values; after release, the first Addr is RESET_PC.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage constants: FSM state encoding, reset PC, NOP word and PC step.
package mips_fetch_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// IF stage: owns the PC, single-outstanding Req/Ack fetch, one-entry skid buffer on stall, kill of in-flight data on redirect.
// `define FETCH_PERF_CNT_EN adds Fetch_Count / Bubble_Count outputs.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_NPC,
  output logic [31:0] IF_Instr,
  output logic        IF_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Fetch_Count,
  output logic [31:0] Bubble_Count
`endif
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        deliver;
  logic        bubble;
  logic [31:0] redir_pc;

  assign redir_pc  = word_align(Redirect_PC);
  assign IMem_Req  = (state_q == ST_REQ);
  assign IMem_Addr = pc_q;
  assign IF_PC     = if_pc_q;
  assign IF_NPC    = if_pc_q + PC_INC;
  assign IF_Instr  = if_valid_q ? if_instr_q : NOP_INSTR;
  assign IF_Valid  = if_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    pend_d      = pend_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    deliver     = 1'b0;
    bubble      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (Redirect_Valid) pc_d = redir_pc;
        else if (!Stall)    bubble = 1'b1;
      end
      ST_REQ: begin
        if (IMem_Ack) begin
          if (Redirect_Valid) begin
            pc_d   = redir_pc;
            kill_d = 1'b0;
          end else if (kill_q) begin
            // Data belongs to the path a redirect already cancelled.
            pc_d   = pend_q;
            kill_d = 1'b0;
            bubble = !Stall;
          end else begin
            pc_d = pc_q + PC_INC;
            if (Stall) begin
              buf_pc_d    = pc_q;
              buf_instr_d = IMem_Rdata;
              state_d     = ST_HOLD;
            end else begin
              deliver    = 1'b1;
              if_pc_d    = pc_q;
              if_instr_d = IMem_Rdata;
            end
          end
        end else if (Redirect_Valid) begin
          // Address must stay stable until Ack, so park the target.
          kill_d = 1'b1;
          pend_d = redir_pc;
        end else if (!Stall) begin
          bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Redirect_Valid) begin
          pc_d    = redir_pc;
          state_d = ST_REQ;
        end else if (!Stall) begin
          deliver    = 1'b1;
          if_pc_d    = buf_pc_q;
          if_instr_d = buf_instr_q;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (Redirect_Valid) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end else if (deliver) begin
      if_valid_d = 1'b1;
    end else if (bubble) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      pend_q      <= 32'd0;
      buf_pc_q    <= 32'd0;
      buf_instr_q <= NOP_INSTR;
      if_pc_q     <= 32'd0;
      if_instr_q  <= NOP_INSTR;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      pend_q      <= pend_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (deliver && !Redirect_Valid)      fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (!Stall && (Redirect_Valid || bubble)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign Fetch_Count  = fetch_cnt_q;
  assign Bubble_Count = bubble_cnt_q;
`endif

endmodule
